multiplier_scheduler: RTL and testbench

- Shares one signed `multiplier` instance (Baugh-Wooley, two's complement, `width` x `width` -> 2*`width`) among `requesters` independent clients.
- Requests are granted round-robin, operands and product are registered, and each result is returned tagged with the owning requester's index.
- The output has valid/ready backpressure.
- Sits between client datapaths and the shared combinational multiplier.

---
 rtl/multiplier_scheduler.sv | 157 +++++++++++++++
 tb/tb_multiplier_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_scheduler.sv
// Round-robin scheduler sharing one signed Baugh-Wooley multiplier among several clients.
// Two registered stages (operands, product) with valid/ready backpressure on the result.

module multiplier #(
    parameter int width = 8
) (
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic [2*width-1:0] p
);
    localparam int prod_w = 2 * width;

    logic [prod_w-1:0] acc;
    logic [prod_w-1:0] term;
    logic              pp;

    // Partial products that pair exactly one sign bit with a magnitude bit are inverted;
    // the constant 2^width + 2^(2*width-1) absorbs the resulting offset.
    always_comb begin
        acc  = '0;
        term = '0;
        pp   = 1'b0;
        for (int i = 0; i < width; i++) begin
            for (int j = 0; j < width; j++) begin
                pp = a[i] & b[j];
                if ((i == width - 1) != (j == width - 1)) begin
                    pp = ~pp;
                end
                term        = '0;
                term[i + j] = pp;
                acc         = acc + term;
            end
        end
        term             = '0;
        term[width]      = 1'b1;
        term[prod_w - 1] = 1'b1;
        acc              = acc + term;
        p                = acc;
    end
endmodule

module multiplier_scheduler #(
    parameter int width       = 8,
    parameter int requesters  = 4,
    parameter int index_width = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [requesters-1:0]         request,
    input  logic [requesters*width-1:0]   operand0,
    input  logic [requesters*width-1:0]   operand1,
    output logic [requesters-1:0]         grant,
    output logic                          result_valid,
    output logic [2*width-1:0]            result,
    output logic [index_width-1:0]        result_owner,
    input  logic                          result_ready
);
    if (requesters < 2 || requesters > 16 || (1 << index_width) < requesters) begin : g_bad_params
        $error("multiplier_scheduler: requesters must be 2..16 and fit in index_width");
    end

    logic                   s1_valid_q, s1_valid_d;
    logic [width-1:0]       s1_op0_q, s1_op0_d;
    logic [width-1:0]       s1_op1_q, s1_op1_d;
    logic [index_width-1:0] s1_owner_q, s1_owner_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [2*width-1:0]     s2_prod_q, s2_prod_d;
    logic [index_width-1:0] s2_owner_q, s2_owner_d;
    logic [index_width-1:0] ptr_q, ptr_d;

    logic                   stage2_advance;
    logic                   stage1_advance;
    logic                   accept;
    logic                   found;
    logic [index_width-1:0] sel;
    logic [2*width-1:0]     mult_p;

    multiplier #(.width(width)) u_multiplier (
        .a (s1_op0_q),
        .b (s1_op1_q),
        .p (mult_p)
    );

    assign stage2_advance = !s2_valid_q || result_ready;
    assign stage1_advance = !s1_valid_q || stage2_advance;
    assign accept         = stage1_advance && (|request);

    // Search begins just after the last granted client so every client gets a turn.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= requesters; k++) begin
            if (!found && request[(int'(ptr_q) + k) % requesters]) begin
                found = 1'b1;
                sel   = index_width'((int'(ptr_q) + k) % requesters);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (reset_n && stage1_advance && found) begin
            grant[sel] = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op0_d   = s1_op0_q;
        s1_op1_d   = s1_op1_q;
        s1_owner_d = s1_owner_q;
        ptr_d      = ptr_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_owner_d = s2_owner_q;
        if (stage1_advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op0_d   = operand0[int'(sel) * width +: width];
                s1_op1_d   = operand1[int'(sel) * width +: width];
                s1_owner_d = sel;
                ptr_d      = sel;
            end
        end
        if (stage2_advance) begin
            s2_valid_d = s1_valid_q;
            s2_prod_d  = mult_p;
            s2_owner_d = s1_owner_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op0_q   <= '0;
            s1_op1_q   <= '0;
            s1_owner_q <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_owner_q <= '0;
            ptr_q      <= index_width'(requesters - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op0_q   <= s1_op0_d;
            s1_op1_q   <= s1_op1_d;
            s1_owner_q <= s1_owner_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_owner_q <= s2_owner_d;
            ptr_q      <= ptr_d;
        end
    end

    assign result_valid = s2_valid_q;
    assign result       = s2_prod_q;
    assign result_owner = s2_owner_q;
endmodule

// File: tb/tb_multiplier_scheduler.sv
// Bench for multiplier_scheduler: transaction-level queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_multiplier_scheduler;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [R-1:0]      request;
    logic [R*W-1:0]    operand0;
    logic [R*W-1:0]    operand1;
    logic [R-1:0]      grant;
    logic              result_valid;
    logic [2*W-1:0]    result;
    logic [IW-1:0]     result_owner;
    logic              result_ready;

    int total = 0;
    int bad   = 0;

    multiplier_scheduler #(.width(W), .requesters(R), .index_width(IW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .request      (request),
        .operand0     (operand0),
        .operand1     (operand1),
        .grant        (grant),
        .result_valid (result_valid),
        .result       (result),
        .result_owner (result_owner),
        .result_ready (result_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ops in flight kept oldest-first with the cycle they were granted.
    int               q_owner[$];
    logic [2*W-1:0]   q_prod[$];
    int               q_cyc[$];
    int               m_ptr = R - 1;
    int               cyc = 0;
    bit               m_valid;
    bit               m_room;
    int               m_gidx;
    logic [R-1:0]     m_grant;
    logic signed [W-1:0] ma, mb;
    int               ia, ib, pr;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            q_owner.delete();
            q_prod.delete();
            q_cyc.delete();
            m_ptr = R - 1;
            chk("reset_grant", grant, '0);
            chk("reset_valid", result_valid, 1'b0);
            chk("reset_result", result, '0);
            chk("reset_owner", result_owner, '0);
        end else begin
            m_valid = (q_cyc.size() > 0) && (cyc - q_cyc[0] >= 2);
            m_room  = (q_cyc.size() < 2) || (m_valid && result_ready);
            m_gidx  = -1;
            m_grant = '0;
            if (m_room) begin
                for (int k = 1; k <= R; k++) begin
                    if (m_gidx < 0 && request[(m_ptr + k) % R]) m_gidx = (m_ptr + k) % R;
                end
            end
            if (m_gidx >= 0) m_grant[m_gidx] = 1'b1;
            chk("model_grant", grant, m_grant);
            chk("model_valid", result_valid, m_valid);
            if (m_valid) begin
                chk("model_result", result, q_prod[0]);
                chk("model_owner", result_owner, q_owner[0]);
            end
            if (m_valid && result_ready) begin
                void'(q_owner.pop_front());
                void'(q_prod.pop_front());
                void'(q_cyc.pop_front());
            end
            if (m_gidx >= 0) begin
                ma = operand0[m_gidx*W +: W];
                mb = operand1[m_gidx*W +: W];
                ia = ma;
                ib = mb;
                pr = ia * ib;
                q_owner.push_back(m_gidx);
                q_prod.push_back(pr[2*W-1:0]);
                q_cyc.push_back(cyc);
                m_ptr = m_gidx;
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic set_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        operand0[c*W +: W] = a;
        operand1[c*W +: W] = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        request = '0;
        result_ready = 1'b1;
        nxt();
        nxt();
        reset_n = 1'b1;
    endtask

    task automatic run_single(input string nm, input int c, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [2*W-1:0] exp);
        set_op(c, a, b);
        request = '0;
        request[c] = 1'b1;
        mid();
        chk({nm, "_grant"}, grant, 64'(1) << c);
        nxt();
        request = '0;
        mid();
        chk({nm, "_t1_valid"}, result_valid, 1'b0);
        nxt();
        mid();
        chk({nm, "_valid"}, result_valid, 1'b1);
        chk({nm, "_result"}, result, exp);
        chk({nm, "_owner"}, result_owner, c);
        nxt();
    endtask

    logic [W-1:0] corner [4];

    initial begin
        reset_n = 1'b0;
        request = '0;
        operand0 = '0;
        operand1 = '0;
        result_ready = 1'b1;
        corner[0] = 8'h80;
        corner[1] = 8'h7F;
        corner[2] = 8'h00;
        corner[3] = 8'hFF;
        nxt();
        nxt();
        reset_n = 1'b1;
        mid();
        chk("idle_valid", result_valid, 1'b0);
        nxt();

        run_single("single", 2, 8'hFD, 8'h05, 16'hFFF1);
        run_single("neg_neg", 1, 8'h80, 8'h80, 16'h4000);
        run_single("neg_pos", 3, 8'h80, 8'h7F, 16'hC080);
        run_single("zero", 0, 8'h00, 8'hFF, 16'h0000);
        run_single("pos_pos", 2, 8'h7F, 8'h7F, 16'h3F01);

        // Fairness with everyone requesting and no stalls
        do_reset();
        operand0 = $urandom;
        operand1 = $urandom;
        request = 4'hF;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("fair_grant", grant, 64'(1) << (k % 4));
            if (k >= 2) begin
                chk("fair_valid", result_valid, 1'b1);
                chk("fair_owner", result_owner, (k - 2) % 4);
            end
            nxt();
        end

        // Backpressure: two fill the pipe, then grants stop until ready returns
        do_reset();
        result_ready = 1'b0;
        set_op(0, 8'h07, 8'hF7);
        set_op(1, 8'h9C, 8'h32);
        request = 4'b0011;
        mid();
        chk("bp_grant0", grant, 4'b0001);
        nxt();
        mid();
        chk("bp_grant1", grant, 4'b0010);
        nxt();
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("bp_stall_grant", grant, 4'b0000);
            chk("bp_stall_valid", result_valid, 1'b1);
            chk("bp_stall_result", result, 16'hFFC1);
            chk("bp_stall_owner", result_owner, 0);
            nxt();
        end
        result_ready = 1'b1;
        mid();
        chk("bp_resume_grant", grant, 4'b0001);
        chk("bp_res0_result", result, 16'hFFC1);
        chk("bp_res0_owner", result_owner, 0);
        nxt();
        mid();
        chk("bp_res1_valid", result_valid, 1'b1);
        chk("bp_res1_result", result, 16'hEC78);
        chk("bp_res1_owner", result_owner, 1);
        nxt();
        request = '0;
        repeat (3) nxt();

        // Reset one cycle after a grant
        request = 4'hF;
        mid();
        nxt();
        reset_n = 1'b0;
        mid();
        chk("rst_mid_valid", result_valid, 1'b0);
        nxt();
        nxt();
        reset_n = 1'b1;
        request = '0;
        mid();
        chk("rst_after_valid0", result_valid, 1'b0);
        nxt();
        mid();
        chk("rst_after_valid1", result_valid, 1'b0);
        nxt();
        request = 4'hF;
        mid();
        chk("rst_first_grant", grant, 4'b0001);
        nxt();

        // Pointer wrap from client 3 to client 0
        request = 4'b1000;
        mid();
        chk("wrap_grant3", grant, 4'b1000);
        nxt();
        request = 4'b0001;
        mid();
        chk("wrap_grant0", grant, 4'b0001);
        nxt();
        request = '0;
        repeat (3) nxt();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            request = 4'($urandom_range(0, 15));
            operand0 = $urandom;
            operand1 = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < R; c++) begin
                    set_op(c, corner[$urandom_range(0, 3)], corner[$urandom_range(0, 3)]);
                end
            end
            result_ready = ($urandom_range(0, 3) != 0);
            reset_n = ($urandom_range(0, 599) != 0);
            nxt();
        end
        reset_n = 1'b1;
        request = '0;
        result_ready = 1'b1;
        repeat (5) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
